// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I sequencing controller: state codes,
// opcodes and the datapath select-field values.
package ctrl_pkg;

  typedef logic [3:0] stateT;

  localparam stateT StFetch    = 4'd0;
  localparam stateT StDecode   = 4'd1;
  localparam stateT StMemAdr   = 4'd2;
  localparam stateT StMemRead  = 4'd3;
  localparam stateT StMemWb    = 4'd4;
  localparam stateT StMemWrite = 4'd5;
  localparam stateT StExecR    = 4'd6;
  localparam stateT StExecI    = 4'd7;
  localparam stateT StAluWb    = 4'd8;
  localparam stateT StBranch   = 4'd9;
  localparam stateT StJal      = 4'd10;
  localparam stateT StJalr1    = 4'd11;
  localparam stateT StJalr2    = 4'd12;
  localparam stateT StLui      = 4'd13;
  localparam stateT StAuipc    = 4'd14;
  localparam stateT StTrap     = 4'd15;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARd1   = 2'b10;

  localparam logic [1:0] SrcBRd2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] AluAdd    = 2'b00;
  localparam logic [1:0] AluBranch = 2'b01;
  localparam logic [1:0] AluFunct  = 2'b10;
  localparam logic [1:0] AluPassB  = 2'b11;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b011;
  localparam logic [2:0] ImmU = 3'b100;

  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

  function automatic logic isWaitState(input stateT s);
    return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
  endfunction

endpackage

// File: rtl/imm_src_decoder.sv
// Combinational opcode to immediate-format select; unknown opcodes give the I format.
module imm_src_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] immSrc
);

  always_comb begin
    immSrc = ImmI;
    case (op)
      OpStore:        immSrc = ImmS;
      OpBranch:       immSrc = ImmB;
      OpJal:          immSrc = ImmJ;
      OpLui, OpAuipc: immSrc = ImmU;
      default:        immSrc = ImmI;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I sequencer: steps each instruction through the shared datapath,
// with memory-wait timeout, sticky trap and retired-instruction counter.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned INSTRET_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCUpdate,
  output logic                 Branch,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [2:0]           ImmSrc,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret
);

  localparam int unsigned WaitW = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);

  stateT                stateQ, stateD;
  logic [WaitW-1:0]     waitQ, waitD;
  logic [INSTRET_W-1:0] instretQ, instretD;
  logic                 trapQ, trapD;
  logic [1:0]           causeQ, causeD;
  logic                 retire;
  logic                 timeout;

  imm_src_decoder uImmSrc (
    .op     (op),
    .immSrc (ImmSrc)
  );

  // waitQ counts cycles already spent waiting; this cycle would be the WAIT_LIMIT-th.
  assign timeout = (WAIT_LIMIT != 0) && isWaitState(stateQ) && !mem_ready &&
                   (waitQ == WaitLast);

  always_comb begin
    stateD = stateQ;
    causeD = causeQ;
    retire = 1'b0;
    case (stateQ)
      StFetch:    if (mem_ready) stateD = StDecode;
      StDecode: begin
        case (op)
          OpLoad, OpStore: stateD = StMemAdr;
          OpReg:           stateD = StExecR;
          OpImm:           stateD = StExecI;
          OpBranch:        stateD = StBranch;
          OpJal:           stateD = StJal;
          OpJalr:          stateD = StJalr1;
          OpLui:           stateD = StLui;
          OpAuipc:         stateD = StAuipc;
          default: begin
            stateD = StTrap;
            causeD = CauseIllegal;
          end
        endcase
      end
      StMemAdr:   stateD = (op == OpStore) ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) stateD = StMemWb;
      StMemWb: begin
        stateD = StFetch;
        retire = 1'b1;
      end
      StMemWrite: begin
        if (mem_ready) begin
          stateD = StFetch;
          retire = 1'b1;
        end
      end
      StExecR, StExecI, StJal, StJalr2, StLui, StAuipc: stateD = StAluWb;
      StJalr1:    stateD = StJalr2;
      StAluWb, StBranch: begin
        stateD = StFetch;
        retire = 1'b1;
      end
      default:    stateD = StTrap;
    endcase
    if (timeout) begin
      stateD = StTrap;
      causeD = CauseTimeout;
    end
  end

  always_comb begin
    trapD    = trapQ | (stateD == StTrap);
    waitD    = (isWaitState(stateQ) && (stateD == stateQ)) ? waitQ + WaitW'(1) : '0;
    instretD = retire ? instretQ + INSTRET_W'(1) : instretQ;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ   <= StFetch;
      waitQ    <= '0;
      instretQ <= '0;
      trapQ    <= 1'b0;
      causeQ   <= CauseNone;
    end else begin
      stateQ   <= stateD;
      waitQ    <= waitD;
      instretQ <= instretD;
      trapQ    <= trapD;
      causeQ   <= causeD;
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCUpdate  = 1'b0;
    Branch    = 1'b0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    ResultSrc = ResAluOut;
    ALUSrcA   = SrcAPc;
    ALUSrcB   = SrcBRd2;
    ALUOp     = AluAdd;
    case (stateQ)
      StFetch: begin
        mem_req   = 1'b1;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluResult;
      end
      StDecode: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
      end
      StMemAdr, StJalr1: begin
        ALUSrcA = SrcARd1;
        ALUSrcB = SrcBImm;
      end
      StMemRead: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      StMemWb: begin
        ResultSrc = ResData;
        RegWrite  = 1'b1;
      end
      StMemWrite: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      StExecR: begin
        ALUSrcA = SrcARd1;
        ALUOp   = AluFunct;
      end
      StExecI: begin
        ALUSrcA = SrcARd1;
        ALUSrcB = SrcBImm;
        ALUOp   = AluFunct;
      end
      StAluWb:  RegWrite = 1'b1;
      StBranch: begin
        ALUSrcA = SrcARd1;
        ALUOp   = AluBranch;
        Branch  = 1'b1;
      end
      StJal, StJalr2: begin
        ALUSrcA  = SrcAOldPc;
        ALUSrcB  = SrcBFour;
        PCUpdate = 1'b1;
      end
      StLui: begin
        ALUSrcB = SrcBImm;
        ALUOp   = AluPassB;
      end
      StAuipc: begin
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
      end
      default: ;
    endcase
  end

  assign trap       = trapQ;
  assign trap_cause = causeQ;
  assign instret    = instretQ;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Sequencing controller for the multicycle RV32I core. It replaces the single-cycle main decoder with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared-datapath multiplexers and enables, and stalls on a memory ready handshake. It also adds capabilities the single-cycle core lacks: a bounded memory-wait timeout, a sticky illegal-instruction/timeout trap, and a retired-instruction counter.

## Interface
Parameters:
- WAIT_LIMIT, 16: maximum consecutive cycles in a memory-wait state without mem_ready before trapping. A value of 0 disables the timeout.
- INSTRET_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0] from the instruction register
- mem_ready  in  1  memory has completed the current access this cycle
- mem_req  out  1  memory access requested
- AdrSrc  out  1  0 = PC, 1 = Result
- IRWrite  out  1  load the instruction register
- PCUpdate  out  1  write the PC unconditionally
- Branch  out  1  write the PC if the ALU comparison is taken
- RegWrite  out  1  register file write enable
- MemWrite  out  1  data memory write enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  00 = add, 01 = branch compare, 10 = funct decode, 11 = pass B
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U; combinational from op
- trap  out  1  sticky fault flag
- trap_cause  out  2  00 = none, 01 = illegal opcode, 10 = memory timeout
- instret  out  INSTRET_W  count of retired instructions

## Operation
States and the controls they assert. Unlisted controls are 0; unlisted select fields are 00.
- FETCH: mem_req, ALUSrcB = 10, ResultSrc = 10.
  - IRWrite and PCUpdate are asserted only in the cycle where mem_ready = 1.
  - On mem_ready go to DECODE, otherwise stay.
- DECODE: ALUSrcA = 01, ALUSrcB = 01 (branch target into ALUOut). Next state by op:
  - 0000011 / 0100011 go to MEMADR.
  - 0110011 goes to EXECR.
  - 0010011 goes to EXECI.
  - 1100011 goes to BRANCH.
  - 1101111 goes to JAL.
  - 1100111 goes to JALR1.
  - 0110111 goes to LUI.
  - 0010111 goes to AUIPC.
  - Any other op goes to TRAP with cause 01.
- MEMADR: ALUSrcA = 10, ALUSrcB = 01. Go to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req, AdrSrc = 1. Hold until mem_ready, then go to MEMWB.
- MEMWB: ResultSrc = 01, RegWrite. Retires and goes to FETCH.
- MEMWRITE: mem_req, AdrSrc = 1, MemWrite. Hold until mem_ready; then retire and go to FETCH.
- EXECR: ALUSrcA = 10, ALUOp = 10. Go to ALUWB.
- EXECI: ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10. Go to ALUWB.
- ALUWB: RegWrite, ResultSrc = 00. Retires and goes to FETCH.
- BRANCH: ALUSrcA = 10, ALUOp = 01, Branch. Retires and goes to FETCH.
- JAL: ALUSrcA = 01, ALUSrcB = 10, PCUpdate. Go to ALUWB.
- JALR1: ALUSrcA = 10, ALUSrcB = 01. Go to JALR2.
- JALR2: ALUSrcA = 01, ALUSrcB = 10, PCUpdate (PC takes the target from ALUOut). Go to ALUWB.
- LUI: ALUSrcB = 01, ALUOp = 11. Go to ALUWB.
- AUIPC: ALUSrcA = 01, ALUSrcB = 01. Go to ALUWB.
- TRAP: all enables and mem_req are 0. trap = 1; trap_cause holds. The only exit is reset.

Counters:
- Wait counter:
  - Clears on entry to any wait state (FETCH, MEMREAD, MEMWRITE) and on mem_ready.
  - Increments each cycle spent waiting.
  - When it reaches WAIT_LIMIT with mem_ready = 0, go to TRAP with cause 10.
  - mem_ready takes priority over timeout in the same cycle.
- instret:
  - Increments by 1 on each retiring transition.
  - Wraps at 2^INSTRET_W.
  - Never increments in TRAP.

## Timing
- Reset is asynchronous and immediate:
  - state = FETCH, wait counter = 0, instret = 0, trap = 0, trap_cause = 00.
  - Outputs during reset are the FETCH values with mem_ready gating (mem_req = 1).
- State, counters and trap are registered. Outputs are Moore decodes of state, except IRWrite and PCUpdate in FETCH, which are combinational with mem_ready.
- Latency with zero wait states:
  - lw: 5 cycles.
  - sw, R-type, I-type, lui, auipc: 4 cycles.
  - beq: 3 cycles.
  - jal: 4 cycles.
  - jalr: 5 cycles.
  - Each memory-wait cycle adds 1.
- Reset asserted mid-instruction abandons it with no retire.
- Reset clears a trap.

## Structure
- Package ctrl_pkg holds:
  - the state enum;
  - the opcode constants;
  - the localparams for the ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc and trap_cause encodings.
- Sub-module imm_src_decoder is the combinational op-to-ImmSrc mapping; unknown ops give 000.
- The FSM, wait counter and instret counter stay in this module.

## Test plan
- lw, mem_ready always 1:
  - States FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH.
  - RegWrite = 1 only in MEMWB with ResultSrc = 01.
  - instret 0 → 1.
- sw, mem_ready low 3 cycles in MEMWRITE:
  - MemWrite and AdrSrc = 1 held for 4 cycles.
  - Retires on the cycle after mem_ready = 1.
- op = 1111111:
  - TRAP entered one cycle after DECODE, with trap = 1 and trap_cause = 01.
  - No further IRWrite, PCUpdate or mem_req until reset.
- WAIT_LIMIT = 4, mem_ready held 0 in FETCH:
  - TRAP with trap_cause = 10 after 4 wait cycles; IRWrite never asserted.
  - Repeat with mem_ready = 1 on the limit cycle: DECODE is entered, no trap.
- jalr, then beq, then auipc:
  - jalr: PCUpdate in JALR2 with ALUSrcA = 01 and ALUSrcB = 10.
  - beq: Branch = 1 for exactly 1 cycle.
  - auipc: ALUSrcA = 01, ALUSrcB = 01, ImmSrc = 100.
  - instret increases by 3.
- Reset pulled low asynchronously in MEMREAD:
  - State returns to FETCH and instret = 0 within the same cycle, without a clock edge.
  - RegWrite stays 0.
